// File: rtl/run_light_decoder.sv
// rtl/run_light_decoder.sv - recovers run_light sequencer mode from the observed LED pattern
module run_light_decoder #(
    parameter int LOCK_N = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] y,
    input  logic       y_vld,
    output logic [1:0] mode,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    localparam logic [3:0] LOCK_N_W = 4'(LOCK_N);

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [1:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       prev_onehot, prev_fill;
    logic       is_hold, is_l, is_r, is_f, is_b, is_a, is_uniq;
    logic [1:0] cls;
    logic [3:0] cnt_inc;
    logic       lock_now;
    logic [1:0] lock_mode;

    // Transition classification of prev -> y
    always_comb begin
        prev_onehot = (prev_q != 8'h00) && ((prev_q & (prev_q - 8'd1)) == 8'h00);
        prev_fill   = ((prev_q & (prev_q + 8'd1)) == 8'h00) && (prev_q != 8'hFF);
        is_hold     = (y == prev_q);
        is_l        = prev_onehot && (y == {prev_q[6:0], prev_q[7]});
        is_r        = prev_onehot && (y == {prev_q[0], prev_q[7:1]});
        is_f        = prev_fill && (y == {prev_q[6:0], 1'b1});
        is_b        = (prev_q == 8'h00) && (y == 8'hFF);
        is_a        = (prev_q == 8'hFF) && (y == 8'h00);
        is_uniq     = is_l || is_r || is_f || is_b;
        if (is_l)      cls = 2'd0;
        else if (is_r) cls = 2'd1;
        else if (is_f) cls = 2'd2;
        else           cls = 2'd3;
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        cnt_inc   = cnt_q + 4'd1;
        lock_now  = 1'b0;
        lock_mode = cand_q;

        if (y_vld) begin
            prev_d = y;
            case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (!is_hold && is_uniq) begin
                        cand_d    = cls;
                        cnt_d     = 4'd1;
                        state_d   = ST_TRACK;
                        lock_now  = (LOCK_N_W <= 4'd1);
                        lock_mode = cls;
                    end
                end
                ST_TRACK: begin
                    if (is_hold) begin
                        state_d = ST_TRACK;
                    end else if (is_uniq && cls == cand_q) begin
                        cnt_d    = cnt_inc;
                        lock_now = (cnt_inc >= LOCK_N_W);
                    end else if (is_uniq) begin
                        cand_d    = cls;
                        cnt_d     = 4'd1;
                        lock_now  = (LOCK_N_W <= 4'd1);
                        lock_mode = cls;
                    end else if (!(is_a && cand_q[1])) begin
                        state_d = ST_HUNT;
                        cnt_d   = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // A (FF->00) is legal only for fill and blink, whose cand has bit 1 set
                    if (!(is_hold || (is_uniq && cls == cand_q) || (is_a && cand_q[1]))) begin
                        err_d     = 1'b1;
                        locked_d  = 1'b0;
                        err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
                        if (is_uniq) begin
                            state_d = ST_TRACK;
                            cand_d  = cls;
                            cnt_d   = 4'd1;
                        end else begin
                            state_d = ST_HUNT;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (lock_now) begin
            state_d  = ST_LOCKED;
            mode_d   = lock_mode;
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= 8'h00;
            cand_q    <= 2'd0;
            cnt_q     <= 4'd0;
            mode_q    <= 2'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mode    = mode_q;
    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_run_light_decoder.sv
// tb/tb_run_light_decoder.sv - directed-vector bench for run_light_decoder
module tb_run_light_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] y = 8'h00;
    logic       y_vld = 1'b0;
    logic [1:0] mode;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    run_light_decoder #(.LOCK_N(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .y       (y),
        .y_vld   (y_vld),
        .mode    (mode),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents one sample for a single edge; outputs are observed 1 time unit after it.
    task automatic feed(input logic [7:0] v);
        y     = v;
        y_vld = 1'b1;
        @(posedge clk);
        #1;
        y_vld = 1'b0;
    endtask

    task automatic do_reset();
        y_vld = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq1 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    logic [7:0] seq2 [5] = '{8'h02, 8'h01, 8'h80, 8'h40, 8'h20};
    logic [7:0] seq3 [10] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    logic [7:0] seq4 [9] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] relock [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

    initial begin
        int err_seen;
        #3;
        check("reset_locked", locked, 0);
        check("reset_mode", mode, 0);
        check("reset_err", err, 0);
        check("reset_err_cnt", err_cnt, 0);
        do_reset();

        // 1: rotate left locks on the fifth sample
        err_seen = 0;
        for (int i = 0; i < 5; i++) begin
            feed(seq1[i]);
            err_seen += err;
            if (i == 3) check("t1_not_yet", locked, 0);
        end
        check("t1_locked", locked, 1);
        check("t1_mode", mode, 0);
        check("t1_no_err", err_seen, 0);

        // 2: rotate right including the 01->80 wrap, then HOLD samples
        do_reset();
        for (int i = 0; i < 5; i++) feed(seq2[i]);
        check("t2_locked", locked, 1);
        check("t2_mode", mode, 1);
        for (int i = 0; i < 3; i++) begin
            feed(8'h20);
            check("t2_hold_locked", locked, 1);
            check("t2_hold_err", err, 0);
        end
        check("t2_hold_mode", mode, 1);

        // 3: fill locks and tolerates the FF->00 wrap
        do_reset();
        err_seen = 0;
        for (int i = 0; i < 5; i++) feed(seq3[i]);
        check("t3_locked", locked, 1);
        check("t3_mode", mode, 2);
        for (int i = 5; i < 10; i++) begin
            feed(seq3[i]);
            err_seen += err;
            check("t3_stay_locked", locked, 1);
        end
        feed(8'h01);
        err_seen += err;
        check("t3_no_err", err_seen, 0);
        check("t3_final_locked", locked, 1);

        // 4: blink, A steps do not count toward lock
        do_reset();
        for (int i = 0; i < 8; i++) feed(seq4[i]);
        check("t4_not_yet", locked, 0);
        feed(seq4[8]);
        check("t4_locked", locked, 1);
        check("t4_mode", mode, 3);

        // 5: error while locked in rotate-left, then relock
        do_reset();
        feed(8'h80); feed(8'h01); feed(8'h02); feed(8'h04); feed(8'h08);
        check("t5_locked", locked, 1);
        feed(8'h0A);
        check("t5_err", err, 1);
        check("t5_err_cnt", err_cnt, 1);
        check("t5_unlocked", locked, 0);
        feed(8'h0A);
        check("t5_err_one_cycle", err, 0);
        feed(8'h14);
        check("t5_still_unlocked", locked, 0);
        for (int i = 0; i < 5; i++) feed(relock[i]);
        check("t5_relocked", locked, 1);
        check("t5_relock_mode", mode, 0);
        check("t5_err_cnt_kept", err_cnt, 1);

        // 6: asynchronous reset while locked in fill
        do_reset();
        for (int i = 0; i < 5; i++) feed(seq3[i]);
        check("t6_locked", locked, 1);
        feed(8'h3F);
        check("t6_err_before", err, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_locked", locked, 0);
        check("t6_async_mode", mode, 0);
        check("t6_async_err", err, 0);
        check("t6_async_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        feed(8'h01);
        check("t6_idle_load", locked, 0);
        feed(8'h03);
        check("t6_first_count", locked, 0);

        // 7: err_cnt saturates at 255 while err keeps pulsing
        do_reset();
        feed(8'h33);
        for (int i = 0; i < 5; i++) feed(relock[i]);
        for (int n = 0; n < 255; n++) begin
            feed(8'h33);
            for (int i = 0; i < 5; i++) feed(relock[i]);
        end
        check("t7_cnt_255", err_cnt, 255);
        check("t7_locked", locked, 1);
        feed(8'h33);
        check("t7_err_pulse", err, 1);
        check("t7_cnt_sat", err_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_light_decoder.md
# run_light_decoder

Receive-side companion to the `run_light` LED sequencer. Samples the 8-bit light pattern `Y` on a per-step strobe and classifies successive transitions. Recovers which of the four sequencer modes (`S` = 0..3) is running, and asserts lock after a configurable streak of consistent steps. Flags and counts steps that break the locked pattern, so benches and on-board monitors can check the sequencer without knowing `S`.

## Interface
- `LOCK_N`, default 4: consecutive counted matches required to lock; legal range 1..15.
- `clk`, input, 1: system clock, rising-edge.
- `reset`, input, 1: asynchronous, active-low; clears all state and outputs immediately.
- `y`, input, 8: observed light pattern.
- `y_vld`, input, 1: `y` holds a new step this cycle.
- `mode`, output, 2: recovered mode, valid while `locked`=1.
- `locked`, output, 1: pattern recognised and tracking.
- `err`, output, 1: one-cycle pulse on a step that breaks the locked pattern.
- `err_cnt`, output, 8: count of `err` pulses, saturates at 255.

## Operation
- Mode patterns (sequencer contract):
  - 0: one-hot rotate left (80→01 wraps).
  - 1: one-hot rotate right (01→80 wraps).
  - 2: fill, 00→01→03→…→FF→00.
  - 3: blink, FF↔00.
- Transition class, computed from stored `prev` and new `y` on `y_vld`:
  - `y`==`prev`: HOLD. Ignored entirely; no state, counter or output change.
  - L: `prev` one-hot and `y`==rol(`prev`).
  - R: `prev` one-hot and `y`==ror(`prev`).
  - F: `prev`≠FF and `y`=={`prev`[6:0],1}. `prev` must be a fill value (00,01,03,…,7F).
  - B: `prev`==00, `y`==FF.
  - A (ambiguous): `prev`==FF, `y`==00. Compatible with modes 2 and 3 only.
  - N: none of the above.
- `prev` loads `y` on every `y_vld`, including N steps.
- FSM states:
  - IDLE: first `y_vld` loads `prev` → HUNT.
  - HUNT: unique class (L/R/F/B) → TRACK with `cand` = class mode, `cnt`=1. A or N → stay in HUNT.
  - TRACK:
    - Class matches `cand` → `cnt`+1.
    - A with `cand`∈{2,3} → no count, stay.
    - Other unique class → `cand` = new class, `cnt`=1.
    - A with `cand`∈{0,1}, or N → HUNT, `cnt`=0.
    - When `cnt` reaches `LOCK_N` → LOCKED, `mode`←`cand`, `locked`←1.
    - With `LOCK_N`=1, the first unique class in HUNT goes directly to LOCKED.
  - LOCKED:
    - Matching class, compatible A, or HOLD → stay, no error.
    - Any other step: `err` pulses, `err_cnt`+1 (saturating), `locked`←0.
    - After an error: a unique other class → TRACK with that class, `cnt`=1; otherwise → HUNT.
    - `mode` keeps its last locked value until the next lock.
- All outputs are registered.

## Timing
- Reset values: `mode`=0, `locked`=0, `err`=0, `err_cnt`=0, FSM=IDLE, `cnt`=0, `prev`=00. Assertion is asynchronous; release is sampled at the next rising edge.
- Latency: one cycle. `locked`/`mode`/`err`/`err_cnt` update on the edge that samples the qualifying `y_vld`, and are visible the following cycle.
- `err` is high for exactly one cycle per offending step. Back-to-back offending steps are impossible because lock drops on the first one.
- `y_vld` may be asserted every cycle or sparsely. No minimum gap. `y` is ignored when `y_vld`=0.
- `err_cnt` at 255 stays at 255; `err` still pulses.
- Reset mid-lock: outputs clear immediately; the next `y_vld` after release only loads `prev`.

## Test plan
1. `LOCK_N`=4; after reset, `y_vld` every cycle with 01,02,04,08,10 → `locked`=1, `mode`=0 one cycle after the 10 sample; `err`=0 throughout.
2. Feed 02,01,80,40,20 → `mode`=1, `locked`=1 (01→80 wrap counts). Then repeat 20 three times with `y_vld` → no change.
3. Feed 00,01,03,07,0F → lock, `mode`=2. Continue 1F,3F,7F,FF,00,01 → stays locked, `err` never asserted.
4. Feed FF,00,FF,00,FF,00,FF,00,FF → `locked` rises only after the 9th sample (A steps not counted), `mode`=3.
5. Locked in `mode` 0 at 08, feed 0A → `err` high one cycle, `err_cnt`=1, `locked`=0, FSM in HUNT. Then 0A,14 (N) → still unlocked. Then 01,02,04,08,10 → relock in `mode` 0, `err_cnt` stays 1.
6. Locked in `mode` 2, pull `reset` low between clock edges → all outputs 0 before the next edge. Release, feed 01 → `locked` stays 0 (IDLE only loads `prev`).
